// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand/writeback sequencer: opcodes, writeback
// selects and the sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] OP_ZERO   = 5'b00000;
  localparam logic [4:0] OP_PASS_A = 5'b00100;
  localparam logic [4:0] OP_PASS_B = 5'b00101;
  localparam logic [4:0] OP_ADD    = 5'b01010;
  localparam logic [4:0] OP_SUB    = 5'b01011;
  localparam logic [4:0] OP_AND    = 5'b01100;
  localparam logic [4:0] OP_OR     = 5'b01101;
  localparam logic [4:0] OP_XOR    = 5'b01110;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_NOP    = 5'b11000;

  localparam logic [4:0] CTRL_IDLE     = OP_PASS_A;
  localparam logic [4:0] OP_LAST_LEGAL = 5'b11000;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ACC  = 2'b01;
  localparam logic [1:0] WB_REG  = 2'b10;
  localparam logic [1:0] WB_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_reg_bank.sv
// Operand register bank: async read, writeback port plus external load port;
// the writeback port wins when both target the same register.
module alu_reg_bank #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && wb_addr == RA_W'(i))      regs_q[i] <= wb_data;
        else if (ld_en && ld_addr == RA_W'(i)) regs_q[i] <= ld_data;
      end
    end
  end

  assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/alu_exec_seq.sv
// Sequencer around the external combinational ALU: IDLE -> EXEC -> WB per
// command, feeding ALU operands and retiring the result to ACC and/or the bank.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int NREGS  = 8,
  parameter int RA_W   = 3
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RA_W-1:0]   cmd_src,
  input  logic [RA_W-1:0]   cmd_dst,
  input  logic [1:0]        cmd_wb,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [OP_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0] alu_b_bus,
  output logic [DATA_W-1:0] alu_acc,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [DATA_W-1:0] acc_q,
  output logic              z_flag,
  output logic              n_flag,
  output logic              done,
  output logic              err
);

  localparam logic [OP_W-1:0] CTRL_IDLE_W = OP_W'(CTRL_IDLE);
  localparam logic [OP_W-1:0] OP_NOP_W    = OP_W'(OP_NOP);
  localparam logic [OP_W-1:0] OP_LAST_W   = OP_W'(OP_LAST_LEGAL);

  seq_state_e        state_q;
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   alu_ctrl_q;
  logic [RA_W-1:0]   src_q;
  logic [RA_W-1:0]   dst_q;
  logic [1:0]        wb_q;
  logic [DATA_W-1:0] res_q;
  logic              z_q;
  logic              cmd_ready_q;
  logic              done_q;
  logic              err_q;

  logic              cmd_fire;
  logic              cmd_illegal;
  logic              op_illegal;
  logic              op_commit;
  logic              wb_acc_en;
  logic              wb_reg_en;
  logic [DATA_W-1:0] acc_d;

  assign cmd_fire    = cmd_valid && cmd_ready_q;
  assign cmd_illegal = cmd_op > OP_LAST_W;
  assign op_illegal  = op_q > OP_LAST_W;
  // Only legal, non-NOP ops touch ACC, bank or flags.
  assign op_commit   = op_q < OP_NOP_W;

  always_comb begin
    wb_acc_en = 1'b0;
    wb_reg_en = 1'b0;
    if (state_q == ST_WB && op_commit) begin
      wb_acc_en = wb_q[0];
      wb_reg_en = wb_q[1];
    end
  end

  assign acc_d = wb_acc_en ? res_q : acc_q;

  alu_reg_bank #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .RA_W   (RA_W)
  ) u_bank (
    .clk     (clk_100),
    .rst     (rst),
    .wb_en   (wb_reg_en),
    .wb_addr (dst_q),
    .wb_data (res_q),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (src_q),
    .rd_data (alu_b_bus)
  );

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      wb_q        <= WB_NONE;
      alu_ctrl_q  <= CTRL_IDLE_W;
      res_q       <= '0;
      z_q         <= 1'b1;
      acc_q       <= '0;
      z_flag      <= 1'b1;
      n_flag      <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      acc_q  <= acc_d;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            op_q        <= cmd_op;
            src_q       <= cmd_src;
            dst_q       <= cmd_dst;
            wb_q        <= cmd_wb;
            // Illegal opcodes never reach the ALU; it keeps passing A.
            alu_ctrl_q  <= cmd_illegal ? CTRL_IDLE_W : cmd_op;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q      <= alu_out;
          z_q        <= alu_z;
          alu_ctrl_q <= CTRL_IDLE_W;
          done_q     <= 1'b1;
          err_q      <= op_illegal;
          state_q    <= ST_WB;
        end
        ST_WB: begin
          if (op_commit) begin
            z_flag <= z_q;
            n_flag <= res_q[DATA_W-1];
          end
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          alu_ctrl_q  <= CTRL_IDLE_W;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_acc   = acc_q;

endmodule
